// File: rtl/dc_wr_fifo.sv
// In-order store buffer feeding the data-cache write port, with load/store overlap detection.
// Define DC_WR_FIFO_EXACT_CONFLICT_EN for byte-exact overlap instead of the 16-byte line test.
module dc_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_st_valid,
  input  logic [31:0]      wb_st_addr,
  input  logic [63:0]      wb_st_data,
  input  logic [1:0]       wb_st_size,
  input  logic             mem_wr_done,
  input  logic             v_mem_read,
  input  logic [31:0]      mem_rd_addr,
  input  logic [1:0]       mem_rd_size,
  output logic [31:0]      mem_wr_addr,
  output logic [63:0]      mem_wr_data,
  output logic [1:0]       mem_wr_size,
  output logic             wr_fifo_empty,
  output logic             wr_fifo_full,
  output logic             wr_fifo_to_be_full,
  output logic [PTR_W:0]   wr_fifo_count,
  output logic             mem_conflict,
  output logic             wr_fifo_err
);

  localparam logic [PTR_W:0] C_DEPTH    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH_M1 = (PTR_W+1)'(DEPTH - 1);

`ifdef DC_WR_FIFO_EXACT_CONFLICT_EN
  localparam int END_LSB = 0;
`else
  localparam int END_LSB = 4;
`endif

  logic [31:0]      r_addr [DEPTH];
  logic [63:0]      r_data [DEPTH];
  logic [1:0]       r_size [DEPTH];
  logic [31:END_LSB] r_end [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             r_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_err_evt;
  logic [31:0]      w_st_end;
  logic [31:0]      w_rd_end;
  logic             w_hit;

  assign w_full    = (r_count == C_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_push    = wb_st_valid && !w_full;
  assign w_pop     = mem_wr_done && !w_empty;
  assign w_err_evt = (wb_st_valid && w_full) || (mem_wr_done && w_empty);

  // Last byte touched; carry past bit 31 is discarded so ranges wrap modulo 2^32.
  assign w_st_end = wb_st_addr + (32'd1 << wb_st_size) - 32'd1;
  assign w_rd_end = mem_rd_addr + (32'd1 << mem_rd_size) - 32'd1;

  // NOTE: payload storage has no reset; the valid bits and count alone decide
  // whether an entry is live, so resetting 100+ bits per entry buys nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= wb_st_addr;
      r_data[r_wptr] <= wb_st_data;
      r_size[r_wptr] <= wb_st_size;
      r_end[r_wptr]  <= w_st_end[31:END_LSB];
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values, which is what lets push and pop both see the old count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_valid[r_wptr] <= 1'b1;
        r_wptr          <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_err_evt) r_err <= 1'b1;
    end
  end

  // NOTE: w_hit gets its default before the loop so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) begin
`ifdef DC_WR_FIFO_EXACT_CONFLICT_EN
        if ((w_rd_end < mem_rd_addr) || (r_end[i] < r_addr[i]) ||
            ((mem_rd_addr <= r_end[i]) && (r_addr[i] <= w_rd_end)))
          w_hit = 1'b1;
`else
        if ((r_addr[i][31:4] == mem_rd_addr[31:4]) || (r_addr[i][31:4] == w_rd_end[31:4]) ||
            (r_end[i] == mem_rd_addr[31:4])         || (r_end[i] == w_rd_end[31:4]))
          w_hit = 1'b1;
`endif
      end
    end
  end

  assign mem_conflict = v_mem_read && w_hit;

  assign mem_wr_addr = w_empty ? 32'd0 : r_addr[r_rptr];
  assign mem_wr_data = w_empty ? 64'd0 : r_data[r_rptr];
  assign mem_wr_size = w_empty ? 2'd0  : r_size[r_rptr];

  assign wr_fifo_empty      = w_empty;
  assign wr_fifo_full       = w_full;
  assign wr_fifo_to_be_full = (r_count >= C_DEPTH_M1);
  assign wr_fifo_count      = r_count;
  assign wr_fifo_err        = r_err;

endmodule

// File: tb/tb_dc_wr_fifo.sv
// Bench for dc_wr_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_dc_wr_fifo;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wb_st_valid;
  logic [31:0]      wb_st_addr;
  logic [63:0]      wb_st_data;
  logic [1:0]       wb_st_size;
  logic             mem_wr_done;
  logic             v_mem_read;
  logic [31:0]      mem_rd_addr;
  logic [1:0]       mem_rd_size;
  logic [31:0]      mem_wr_addr;
  logic [63:0]      mem_wr_data;
  logic [1:0]       mem_wr_size;
  logic             wr_fifo_empty;
  logic             wr_fifo_full;
  logic             wr_fifo_to_be_full;
  logic [PTR_W:0]   wr_fifo_count;
  logic             mem_conflict;
  logic             wr_fifo_err;

  always #5 clk = ~clk;

  dc_wr_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_st_valid(wb_st_valid), .wb_st_addr(wb_st_addr), .wb_st_data(wb_st_data), .wb_st_size(wb_st_size),
    .mem_wr_done(mem_wr_done),
    .v_mem_read(v_mem_read), .mem_rd_addr(mem_rd_addr), .mem_rd_size(mem_rd_size),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_size(mem_wr_size),
    .wr_fifo_empty(wr_fifo_empty), .wr_fifo_full(wr_fifo_full), .wr_fifo_to_be_full(wr_fifo_to_be_full),
    .wr_fifo_count(wr_fifo_count), .mem_conflict(mem_conflict), .wr_fifo_err(wr_fifo_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } st_t;

  st_t q[$];
  bit  m_err;
  bit  m_started;
  int  n_checks;
  int  n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference overlap rule, done on 64-bit byte ranges.
  function automatic bit model_conflict();
    longint unsigned rs, re, ss, se;
    bit hit;
    hit = 1'b0;
    if (!v_mem_read) return 1'b0;
    rs = 64'(mem_rd_addr);
    re = rs + (64'd1 << mem_rd_size) - 64'd1;
    foreach (q[i]) begin
      ss = 64'(q[i].addr);
      se = ss + (64'd1 << q[i].size) - 64'd1;
`ifdef DC_WR_FIFO_EXACT_CONFLICT_EN
      if (re > 64'hFFFF_FFFF || se > 64'hFFFF_FFFF || (rs <= se && ss <= re)) hit = 1'b1;
`else
      begin
        longint unsigned sl0, sl1, rl0, rl1;
        sl0 = ss >> 4;
        sl1 = (se % 64'h1_0000_0000) >> 4;
        rl0 = rs >> 4;
        rl1 = (re % 64'h1_0000_0000) >> 4;
        if (sl0 == rl0 || sl0 == rl1 || sl1 == rl0 || sl1 == rl1) hit = 1'b1;
      end
`endif
    end
    return hit;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_err     <= 1'b0;
      m_started <= 1'b1;
    end else begin
      if ((wb_st_valid && q.size() == DEPTH) || (mem_wr_done && q.size() == 0)) m_err <= 1'b1;
      if (wb_st_valid && q.size() < DEPTH) begin
        if (mem_wr_done && q.size() != 0) void'(q.pop_front());
        q.push_back('{addr: wb_st_addr, data: wb_st_data, size: wb_st_size});
      end else if (mem_wr_done && q.size() != 0) begin
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("count",      64'(wr_fifo_count),      64'(q.size()));
      check("empty",      64'(wr_fifo_empty),      64'(q.size() == 0));
      check("full",       64'(wr_fifo_full),       64'(q.size() == DEPTH));
      check("to_be_full", 64'(wr_fifo_to_be_full), 64'(q.size() >= DEPTH - 1));
      check("head_addr",  64'(mem_wr_addr),        (q.size() != 0) ? 64'(q[0].addr) : 64'd0);
      check("head_data",  mem_wr_data,             (q.size() != 0) ? q[0].data : 64'd0);
      check("head_size",  64'(mem_wr_size),        (q.size() != 0) ? 64'(q[0].size) : 64'd0);
      check("err",        64'(wr_fifo_err),        64'(m_err));
      check("conflict",   64'(mem_conflict),       64'(model_conflict()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    wb_st_valid = 1'b1;
    wb_st_addr  = a;
    wb_st_data  = d;
    wb_st_size  = s;
    step();
    wb_st_valid = 1'b0;
  endtask

  task automatic pop();
    mem_wr_done = 1'b1;
    step();
    mem_wr_done = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] s);
    v_mem_read  = 1'b1;
    mem_rd_addr = a;
    mem_rd_size = s;
    #1;
  endtask

`ifdef DC_WR_FIFO_EXACT_CONFLICT_EN
  localparam logic EXP_LINE_ONLY = 1'b0;
`else
  localparam logic EXP_LINE_ONLY = 1'b1;
`endif

  initial begin
    rst_n = 1'b0; wb_st_valid = 1'b0; wb_st_addr = '0; wb_st_data = '0; wb_st_size = '0;
    mem_wr_done = 1'b0; v_mem_read = 1'b0; mem_rd_addr = '0; mem_rd_size = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    check("lit_idle_empty", 64'(wr_fifo_empty), 64'd1);
    check("lit_idle_count", 64'(wr_fifo_count), 64'd0);
    check("lit_idle_addr",  64'(mem_wr_addr),   64'd0);
    check("lit_idle_err",   64'(wr_fifo_err),   64'd0);
    load(32'h100, 2'd2);
    check("lit_idle_conflict", 64'(mem_conflict), 64'd0);
    v_mem_read = 1'b0;

    push(32'h100, 64'hA, 2'd2);
    push(32'h110, 64'hB, 2'd2);
    push(32'h120, 64'hC, 2'd2);
    check("lit_tbf_3",   64'(wr_fifo_to_be_full), 64'd1);
    check("lit_full_3",  64'(wr_fifo_full),       64'd0);
    push(32'h130, 64'hD, 2'd2);
    check("lit_full_4",  64'(wr_fifo_full),  64'd1);
    check("lit_count_4", 64'(wr_fifo_count), 64'd4);
    check("lit_head_a",  64'(mem_wr_addr),   64'h100);
    check("lit_head_d",  mem_wr_data,        64'hA);
    push(32'h140, 64'hE, 2'd2);
    check("lit_ovf_err",   64'(wr_fifo_err),   64'd1);
    check("lit_ovf_count", 64'(wr_fifo_count), 64'd4);

    pop(); check("lit_pop1", 64'(mem_wr_addr), 64'h110);
    pop(); check("lit_pop2", 64'(mem_wr_addr), 64'h120);
    pop(); check("lit_pop3", 64'(mem_wr_addr), 64'h130);
    pop();
    check("lit_drain_empty", 64'(wr_fifo_empty), 64'd1);
    check("lit_drain_data",  mem_wr_data,        64'd0);
    pop();
    check("lit_udf_count", 64'(wr_fifo_count), 64'd0);

    push(32'h300, 64'h1, 2'd3);
    push(32'h310, 64'h2, 2'd3);
    wb_st_valid = 1'b1; wb_st_addr = 32'h320; wb_st_data = 64'h3; wb_st_size = 2'd3;
    mem_wr_done = 1'b1;
    step();
    wb_st_valid = 1'b0; mem_wr_done = 1'b0;
    check("lit_pp_count", 64'(wr_fifo_count), 64'd2);
    check("lit_pp_head",  64'(mem_wr_addr),   64'h310);
    pop(); check("lit_pp_tail", 64'(mem_wr_addr), 64'h320);
    pop();

    push(32'h1FE, 64'h11, 2'd1);
    load(32'h1F0, 2'd3);
    check("lit_cf_same_line", 64'(mem_conflict), 64'(EXP_LINE_ONLY));
    load(32'h200, 2'd0);
    check("lit_cf_next_line", 64'(mem_conflict), 64'd0);

    wb_st_valid = 1'b1; wb_st_addr = 32'h20F; wb_st_data = 64'h22; wb_st_size = 2'd3;
    load(32'h214, 2'd0);
    check("lit_cf_push_same_cycle", 64'(mem_conflict), 64'd0);
    step();
    wb_st_valid = 1'b0;
    #1;
    check("lit_cf_cross_line", 64'(mem_conflict), 64'd1);
    v_mem_read = 1'b0;

    push(32'h100, 64'h33, 2'd0);
    load(32'h104, 2'd0);
    check("lit_cf_line_not_byte", 64'(mem_conflict), 64'(EXP_LINE_ONLY));

    load(32'h1FE, 2'd0);
    mem_wr_done = 1'b1;
    #1;
    check("lit_cf_pop_same_cycle", 64'(mem_conflict), 64'd1);
    step();
    mem_wr_done = 1'b0;
    #1;
    check("lit_cf_after_pop", 64'(mem_conflict), 64'd0);
    v_mem_read = 1'b0;

    push(32'hFFFF_FFFC, 64'h44, 2'd3);
    load(32'h0, 2'd0);
    check("lit_cf_wrap", 64'(mem_conflict), 64'd1);
    v_mem_read = 1'b0;
    check("lit_pre_rst_count", 64'(wr_fifo_count), 64'd3);

    rst_n = 1'b0; mem_wr_done = 1'b1;
    step();
    rst_n = 1'b1; mem_wr_done = 1'b0;
    check("lit_rst_count", 64'(wr_fifo_count), 64'd0);
    check("lit_rst_empty", 64'(wr_fifo_empty), 64'd1);
    check("lit_rst_err",   64'(wr_fifo_err),   64'd0);
    push(32'h500, 64'h55, 2'd2);
    check("lit_post_rst_head", 64'(mem_wr_addr), 64'h500);
    check("lit_post_rst_data", mem_wr_data,       64'h55);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
